// File: rtl/riscv_ifetch_responder_pkg.sv
// Shared types and constants for the RISC-V i32 instruction-fetch responder.
// Optional feature macro used by the top: RISCV_IFETCH_MODE_CHECK_EN.
package riscv_ifetch_responder_pkg;

    localparam logic [2:0] RV_MODE_USER    = 3'b000;
    localparam logic [2:0] RV_MODE_MACHINE = 3'b011;
    localparam logic [2:0] RV_MODE_DEBUG   = 3'b111;

    localparam logic [1:0] STATE_IDLE     = 2'd0;
    localparam logic [1:0] STATE_MEM_WAIT = 2'd1;
    localparam logic [1:0] STATE_DRAIN    = 2'd2;

    typedef struct packed {
        logic        valid;
        logic [28:0] line;
        logic [63:0] data;
    } line_buf_t;

    function automatic logic [31:0] select_word(input logic [63:0] line_data, input logic upper);
        return upper ? line_data[63:32] : line_data[31:0];
    endfunction

endpackage

// File: rtl/riscv_ifetch_line_buffer.sv
// Single 64-bit instruction line buffer: hit compare, word select, fill and invalidate.
// Invalidate has priority over a simultaneous fill.
module riscv_ifetch_line_buffer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        invalidate,
    input  logic        fill_en,
    input  logic [28:0] fill_line,
    input  logic [63:0] fill_data,
    input  logic [28:0] lookup_line,
    input  logic        lookup_upper,
    output logic        hit,
    output logic [31:0] hit_word
);
    import riscv_ifetch_responder_pkg::*;

    line_buf_t line_reg;
    line_buf_t line_next;

    always_comb begin
        line_next = line_reg;
        if (invalidate) begin
            line_next.valid = 1'b0;
        end else if (fill_en) begin
            line_next.valid = 1'b1;
            line_next.line  = fill_line;
            line_next.data  = fill_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            line_reg <= '0;
        end else begin
            line_reg <= line_next;
        end
    end

    assign hit      = line_reg.valid && (line_reg.line == lookup_line);
    assign hit_word = select_word(line_reg.data, lookup_upper);

endmodule

// File: rtl/riscv_i32_ifetch_responder.sv
// Memory-side responder for i32 instruction fetch with a one-line buffer and timed memory port.
// Define RISCV_IFETCH_MODE_CHECK_EN to fault user-mode fetches at or above MACHINE_BASE.
module riscv_i32_ifetch_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] MACHINE_BASE   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ifetch_req__valid,
    input  logic [31:0] ifetch_req__address,
    input  logic        ifetch_req__sequential,
    input  logic [2:0]  ifetch_req__mode,
    input  logic        ifetch_req__flush,
    output logic        ifetch_resp__valid,
    output logic        ifetch_resp__debug,
    output logic [31:0] ifetch_resp__data,
    output logic [2:0]  ifetch_resp__mode,
    output logic        ifetch_resp__error,
    output logic [1:0]  ifetch_resp__tag,
    output logic        mem_req,
    output logic [28:0] mem_address,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    input  logic        mem_error
);
    import riscv_ifetch_responder_pkg::*;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_reg, state_next;
    logic [7:0]  timeout_cnt_reg, timeout_cnt_next;
    logic [1:0]  tag_reg, tag_next;
    logic [28:0] req_line_reg, req_line_next;
    logic        req_upper_reg, req_upper_next;
    logic [2:0]  req_mode_reg, req_mode_next;
    logic        mem_req_reg, mem_req_next;
    logic        resp_valid_reg, resp_valid_next;
    logic [31:0] resp_data_reg, resp_data_next;
    logic        resp_error_reg, resp_error_next;
    logic [2:0]  resp_mode_reg, resp_mode_next;
    logic        resp_debug_reg, resp_debug_next;

    logic        accept;
    logic        misaligned;
    logic        priv_fault;
    logic        lookup_hit;
    logic [31:0] hit_word;
    logic        resp_fire;
    logic        fill_en;
    logic        error_inval;

    assign accept     = (state_reg == STATE_IDLE) && ifetch_req__valid && !ifetch_req__flush;
    assign misaligned = (ifetch_req__address[1:0] != 2'b00);
    // A flush kills a response that is being presented this very cycle.
    assign resp_fire  = resp_valid_reg && !ifetch_req__flush;

`ifdef RISCV_IFETCH_MODE_CHECK_EN
    assign priv_fault = (ifetch_req__address >= MACHINE_BASE) && (ifetch_req__mode == RV_MODE_USER);
    logic unused_inputs;
    assign unused_inputs = ifetch_req__sequential;
`else
    assign priv_fault = 1'b0;
    logic unused_inputs;
    assign unused_inputs = ^{ifetch_req__sequential, MACHINE_BASE};
`endif

    riscv_ifetch_line_buffer u_line_buffer (
        .clk          (clk),
        .reset_n      (reset_n),
        .invalidate   (ifetch_req__flush | error_inval),
        .fill_en      (fill_en),
        .fill_line    (req_line_reg),
        .fill_data    (mem_rdata),
        .lookup_line  (ifetch_req__address[31:3]),
        .lookup_upper (ifetch_req__address[2]),
        .hit          (lookup_hit),
        .hit_word     (hit_word)
    );

    always_comb begin
        state_next       = state_reg;
        timeout_cnt_next = timeout_cnt_reg;
        tag_next         = resp_fire ? (tag_reg + 2'd1) : tag_reg;
        req_line_next    = req_line_reg;
        req_upper_next   = req_upper_reg;
        req_mode_next    = req_mode_reg;
        mem_req_next     = mem_req_reg;
        resp_valid_next  = 1'b0;
        resp_data_next   = 32'h0;
        resp_error_next  = 1'b0;
        resp_mode_next   = 3'b000;
        resp_debug_next  = 1'b0;
        fill_en          = 1'b0;
        error_inval      = 1'b0;

        case (state_reg)
            STATE_IDLE: begin
                if (accept) begin
                    resp_mode_next  = ifetch_req__mode;
                    resp_debug_next = (ifetch_req__mode == RV_MODE_DEBUG);
                    req_mode_next   = ifetch_req__mode;
                    if (misaligned || priv_fault) begin
                        resp_valid_next = 1'b1;
                        resp_error_next = 1'b1;
                    end else if (lookup_hit) begin
                        resp_valid_next = 1'b1;
                        resp_data_next  = hit_word;
                    end else begin
                        state_next       = STATE_MEM_WAIT;
                        mem_req_next     = 1'b1;
                        req_line_next    = ifetch_req__address[31:3];
                        req_upper_next   = ifetch_req__address[2];
                        timeout_cnt_next = 8'd0;
                    end
                end
            end
            STATE_MEM_WAIT: begin
                if (ifetch_req__flush) begin
                    if (mem_ack) begin
                        state_next   = STATE_IDLE;
                        mem_req_next = 1'b0;
                    end else begin
                        state_next = STATE_DRAIN;
                    end
                end else if (mem_ack) begin
                    state_next      = STATE_IDLE;
                    mem_req_next    = 1'b0;
                    resp_valid_next = 1'b1;
                    resp_mode_next  = req_mode_reg;
                    resp_debug_next = (req_mode_reg == RV_MODE_DEBUG);
                    if (mem_error) begin
                        resp_error_next = 1'b1;
                        error_inval     = 1'b1;
                    end else begin
                        resp_data_next = select_word(mem_rdata, req_upper_reg);
                        fill_en        = 1'b1;
                    end
                end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
                    // Report the fault now; the late ack is swallowed in DRAIN.
                    state_next      = STATE_DRAIN;
                    resp_valid_next = 1'b1;
                    resp_error_next = 1'b1;
                    resp_mode_next  = req_mode_reg;
                    resp_debug_next = (req_mode_reg == RV_MODE_DEBUG);
                end else begin
                    timeout_cnt_next = timeout_cnt_reg + 8'd1;
                end
            end
            STATE_DRAIN: begin
                if (mem_ack) begin
                    state_next   = STATE_IDLE;
                    mem_req_next = 1'b0;
                end
            end
            default: begin
                state_next   = STATE_IDLE;
                mem_req_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= STATE_IDLE;
            timeout_cnt_reg <= 8'd0;
            tag_reg         <= 2'd0;
            req_line_reg    <= 29'h0;
            req_upper_reg   <= 1'b0;
            req_mode_reg    <= 3'b000;
            mem_req_reg     <= 1'b0;
            resp_valid_reg  <= 1'b0;
            resp_data_reg   <= 32'h0;
            resp_error_reg  <= 1'b0;
            resp_mode_reg   <= 3'b000;
            resp_debug_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            timeout_cnt_reg <= timeout_cnt_next;
            tag_reg         <= tag_next;
            req_line_reg    <= req_line_next;
            req_upper_reg   <= req_upper_next;
            req_mode_reg    <= req_mode_next;
            mem_req_reg     <= mem_req_next;
            resp_valid_reg  <= resp_valid_next;
            resp_data_reg   <= resp_data_next;
            resp_error_reg  <= resp_error_next;
            resp_mode_reg   <= resp_mode_next;
            resp_debug_reg  <= resp_debug_next;
        end
    end

    assign ifetch_resp__valid = resp_fire;
    assign ifetch_resp__data  = resp_data_reg;
    assign ifetch_resp__error = resp_error_reg;
    assign ifetch_resp__mode  = resp_mode_reg;
    assign ifetch_resp__debug = resp_debug_reg;
    assign ifetch_resp__tag   = tag_reg;
    assign mem_req            = mem_req_reg;
    assign mem_address        = req_line_reg;

endmodule

// File: tb/tb_riscv_i32_ifetch_responder.sv
// Randomized bench for riscv_i32_ifetch_responder with a transaction-level reference model.
// Honors RISCV_IFETCH_MODE_CHECK_EN for the privilege-check expectations.
module tb_riscv_i32_ifetch_responder;

    localparam int          TIMEOUT      = 4;
    localparam logic [31:0] MACHINE_BASE = 32'h8000_0000;

    logic        clk;
    logic        reset_n;
    logic        ifetch_req__valid;
    logic [31:0] ifetch_req__address;
    logic        ifetch_req__sequential;
    logic [2:0]  ifetch_req__mode;
    logic        ifetch_req__flush;
    logic        ifetch_resp__valid;
    logic        ifetch_resp__debug;
    logic [31:0] ifetch_resp__data;
    logic [2:0]  ifetch_resp__mode;
    logic        ifetch_resp__error;
    logic [1:0]  ifetch_resp__tag;
    logic        mem_req;
    logic [28:0] mem_address;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        mem_error;

    riscv_i32_ifetch_responder #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .MACHINE_BASE   (MACHINE_BASE)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .ifetch_req__valid      (ifetch_req__valid),
        .ifetch_req__address    (ifetch_req__address),
        .ifetch_req__sequential (ifetch_req__sequential),
        .ifetch_req__mode       (ifetch_req__mode),
        .ifetch_req__flush      (ifetch_req__flush),
        .ifetch_resp__valid     (ifetch_resp__valid),
        .ifetch_resp__debug     (ifetch_resp__debug),
        .ifetch_resp__data      (ifetch_resp__data),
        .ifetch_resp__mode      (ifetch_resp__mode),
        .ifetch_resp__error     (ifetch_resp__error),
        .ifetch_resp__tag       (ifetch_resp__tag),
        .mem_req                (mem_req),
        .mem_address            (mem_address),
        .mem_ack                (mem_ack),
        .mem_rdata              (mem_rdata),
        .mem_error              (mem_error)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
        logic [1:0]  tag;
        logic [2:0]  mode;
    } resp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          chk_en = 0;
    resp_t       exp_q[$];
    resp_t       cmp_e;
    logic        exp_mreq = 0;
    logic [28:0] exp_maddr = '0;

    // Reference model: the buffered line and the next tag to be delivered.
    logic        m_valid = 0;
    logic [28:0] m_line = '0;
    logic [63:0] m_data = '0;
    logic [1:0]  m_tag = '0;

    logic [31:0] got_data[$];
    logic [1:0]  got_tag[$];
    logic        got_err[$];
    logic [28:0] last_maddr = '0;
    logic [1:0]  exp_tags[6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ifetch_req__valid = 1'b0;
        repeat (n) next_cycle();
    endtask

    task automatic push_exp(input int due, input logic [31:0] data, input logic err, input logic [2:0] mode);
        resp_t e;
        e.due  = due;
        e.data = data;
        e.err  = err;
        e.mode = mode;
        e.tag  = m_tag;
        m_tag  = m_tag + 2'd1;
        exp_q.push_back(e);
    endtask

    // Presents one request in the current cycle (DUT idle) and returns in its response
    // cycle, or in the cycle after the drain ack when the memory timed out.
    task automatic fetch(input logic [31:0] addr, input logic [2:0] mode, input logic seq,
                         input int delay, input logic [63:0] rd, input logic me,
                         input logic hold_next, input logic [31:0] next_addr);
        logic priv;
        ifetch_req__valid      = 1'b1;
        ifetch_req__address    = addr;
        ifetch_req__sequential = seq;
        ifetch_req__mode       = mode;
        ifetch_req__flush      = 1'b0;
        priv = 1'b0;
`ifdef RISCV_IFETCH_MODE_CHECK_EN
        priv = (addr >= MACHINE_BASE) && (mode == 3'b000);
`endif
        if (addr[1:0] != 2'b00 || priv) begin
            push_exp(cyc + 1, 32'h0, 1'b1, mode);
            next_cycle();
        end else if (m_valid && m_line == addr[31:3]) begin
            push_exp(cyc + 1, addr[2] ? m_data[63:32] : m_data[31:0], 1'b0, mode);
            next_cycle();
        end else begin
            next_cycle();
            exp_mreq  = 1'b1;
            exp_maddr = addr[31:3];
            for (int k = 1; k <= delay + 1; k++) begin
                if (k == delay + 1) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd;
                    mem_error = me;
                end
                if (k == delay + 1 && k <= TIMEOUT) begin
                    push_exp(cyc + 1, me ? 32'h0 : (addr[2] ? rd[63:32] : rd[31:0]), me, mode);
                    if (me) begin
                        m_valid = 1'b0;
                    end else begin
                        m_valid = 1'b1;
                        m_line  = addr[31:3];
                        m_data  = rd;
                    end
                end else if (k == TIMEOUT) begin
                    push_exp(cyc + 1, 32'h0, 1'b1, mode);
                end
                if (k == TIMEOUT + 1) begin
                    if (hold_next) ifetch_req__address = next_addr;
                    else ifetch_req__valid = 1'b0;
                end
                next_cycle();
            end
            mem_ack   = 1'b0;
            mem_error = 1'b0;
            exp_mreq  = 1'b0;
        end
    endtask

    task automatic idle_flush();
        idle(1);
        ifetch_req__flush = 1'b1;
        m_valid = 1'b0;
        next_cycle();
        ifetch_req__flush = 1'b0;
    endtask

    // Miss whose outstanding read is aborted by a flush in MEM_WAIT cycle fk; ack in cycle ak >= fk.
    task automatic fetch_flush(input logic [31:0] addr, input int fk, input int ak);
        idle(1);
        if (m_valid && m_line == addr[31:3]) idle_flush();
        ifetch_req__valid   = 1'b1;
        ifetch_req__address = addr;
        ifetch_req__mode    = 3'd3;
        next_cycle();
        exp_mreq  = 1'b1;
        exp_maddr = addr[31:3];
        for (int k = 1; k <= ak; k++) begin
            if (k == fk) begin
                ifetch_req__flush = 1'b1;
                ifetch_req__valid = 1'b0;
                m_valid = 1'b0;
            end
            if (k == ak) begin
                mem_ack   = 1'b1;
                mem_rdata = {$urandom, $urandom};
            end
            next_cycle();
            ifetch_req__flush = 1'b0;
        end
        mem_ack  = 1'b0;
        exp_mreq = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL resp_missing: got none expected response due at cycle %0d", exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                cmp_e = exp_q.pop_front();
                check("resp_valid", 64'(ifetch_resp__valid), 64'd1);
                check("resp_data", 64'(ifetch_resp__data), 64'(cmp_e.data));
                check("resp_error", 64'(ifetch_resp__error), 64'(cmp_e.err));
                check("resp_tag", 64'(ifetch_resp__tag), 64'(cmp_e.tag));
                check("resp_mode", 64'(ifetch_resp__mode), 64'(cmp_e.mode));
                check("resp_debug", 64'(ifetch_resp__debug), 64'(cmp_e.mode == 3'b111));
                got_data.push_back(ifetch_resp__data);
                got_tag.push_back(ifetch_resp__tag);
                got_err.push_back(ifetch_resp__error);
                $display("resp cyc=%0d tag=%0d data=%h err=%0b mode=%0d debug=%0b", cyc,
                         ifetch_resp__tag, ifetch_resp__data, ifetch_resp__error,
                         ifetch_resp__mode, ifetch_resp__debug);
            end else begin
                check("resp_idle", 64'(ifetch_resp__valid), 64'd0);
            end
            check("mem_req", 64'(mem_req), 64'(exp_mreq));
            if (exp_mreq) check("mem_address", 64'(mem_address), 64'(exp_maddr));
            if (mem_req) last_maddr = mem_address;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        logic [31:0] addr;
        logic [2:0]  mode;
        int          sel;

        reset_n = 1'b0;
        ifetch_req__valid = 1'b0;
        ifetch_req__address = '0;
        ifetch_req__sequential = 1'b0;
        ifetch_req__mode = '0;
        ifetch_req__flush = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        mem_error = 1'b0;
        repeat (3) next_cycle();
        reset_n = 1'b1;
        check("rst_resp_valid", 64'(ifetch_resp__valid), 64'd0);
        check("rst_resp_data", 64'(ifetch_resp__data), 64'd0);
        check("rst_resp_error", 64'(ifetch_resp__error), 64'd0);
        check("rst_resp_tag", 64'(ifetch_resp__tag), 64'd0);
        check("rst_resp_mode", 64'(ifetch_resp__mode), 64'd0);
        check("rst_resp_debug", 64'(ifetch_resp__debug), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_address", 64'(mem_address), 64'd0);
        chk_en = 1;

        // Miss, sequential hit, misaligned fault.
        base = got_data.size();
        fetch(32'h1000, 3'd3, 1'b0, 1, 64'hAAAA_BBBB_1111_2222, 1'b0, 1'b0, 32'h0);
        fetch(32'h1004, 3'd3, 1'b1, 0, 64'h0, 1'b0, 1'b0, 32'h0);
        fetch(32'h1002, 3'd3, 1'b0, 0, 64'h0, 1'b0, 1'b0, 32'h0);
        idle(2);
        check("t1_mem_address", 64'(last_maddr), 64'h200);
        check("t1_data", 64'(got_data[base]), 64'h1111_2222);
        check("t1_tag", 64'(got_tag[base]), 64'd0);
        check("t1_error", 64'(got_err[base]), 64'd0);
        check("t2_data", 64'(got_data[base+1]), 64'hAAAA_BBBB);
        check("t2_tag", 64'(got_tag[base+1]), 64'd1);
        check("t3_error", 64'(got_err[base+2]), 64'd1);
        check("t3_data", 64'(got_data[base+2]), 64'd0);

        // Flush during a miss, then the old line must miss again.
        base = got_data.size();
        fetch_flush(32'h2000, 1, 4);
        idle(1);
        check("t4_no_resp", 64'(got_data.size()), 64'(base));
        fetch(32'h1000, 3'd3, 1'b0, 0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 32'h0);
        idle(2);
        check("t4_refetch_address", 64'(last_maddr), 64'h200);
        check("t4_refetch_data", 64'(got_data[base]), 64'h89AB_CDEF);
        check("t4_refetch_tag", 64'(got_tag[base]), 64'd3);

        // Timeout, late ack, next request held through DRAIN.
        base = got_data.size();
        fetch(32'h3000, 3'd3, 1'b0, 7, 64'h5555_6666_7777_8888, 1'b0, 1'b1, 32'h3004);
        fetch(32'h3004, 3'd3, 1'b0, 0, 64'hDEAD_BEEF_0BAD_F00D, 1'b0, 1'b0, 32'h0);
        idle(2);
        check("t5_timeout_error", 64'(got_err[base]), 64'd1);
        check("t5_timeout_tag", 64'(got_tag[base]), 64'd0);
        check("t5_next_data", 64'(got_data[base+1]), 64'hDEAD_BEEF);
        check("t5_next_address", 64'(last_maddr), 64'h600);

        // Reset while waiting on memory; the late ack must be ignored.
        base = got_data.size();
        ifetch_req__valid = 1'b1;
        ifetch_req__address = 32'h5000;
        ifetch_req__mode = 3'd3;
        next_cycle();
        exp_mreq = 1'b1;
        exp_maddr = 29'h0A00;
        next_cycle();
        reset_n = 1'b0;
        ifetch_req__valid = 1'b0;
        next_cycle();
        exp_mreq = 1'b0;
        reset_n = 1'b1;
        m_valid = 1'b0;
        m_tag = 2'd0;
        check("rst_mid_tag", 64'(ifetch_resp__tag), 64'd0);
        mem_ack = 1'b1;
        mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        next_cycle();
        mem_ack = 1'b0;
        idle(2);
        check("rst_mid_no_resp", 64'(got_data.size()), 64'(base));

        // Tag wrap over back-to-back hits.
        base = got_data.size();
        fetch(32'h1000, 3'd3, 1'b0, 0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++)
            fetch(32'h1000 | (32'(i % 2) << 2), 3'd3, 1'b1, 0, 64'h0, 1'b0, 1'b0, 32'h0);
        idle(2);
        for (int i = 0; i < 6; i++)
            check($sformatf("tag_seq_%0d", i), 64'(got_tag[base+i]), 64'(exp_tags[i]));

        // Privileged region: user fault (when enabled), then debug-mode fetch.
        base = got_data.size();
        fetch(32'h8000_0000, 3'd0, 1'b0, 0, 64'hCAFE_F00D_0000_0013, 1'b0, 1'b0, 32'h0);
        fetch(32'h8000_0000, 3'd7, 1'b0, 0, 64'hCAFE_F00D_0000_0013, 1'b0, 1'b0, 32'h0);
        idle(2);
`ifdef RISCV_IFETCH_MODE_CHECK_EN
        check("t6_user_error", 64'(got_err[base]), 64'd1);
`else
        check("t6_user_error", 64'(got_err[base]), 64'd0);
`endif
        check("t6_debug_data", 64'(got_data[base+1]), 64'h0000_0013);

        // Randomized traffic over a few lines.
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 19);
            if (sel == 0) begin
                fetch_flush(32'h4000 + (32'($urandom_range(0, 3)) << 3), $urandom_range(1, 3), $urandom_range(3, 7));
            end else if (sel == 1) begin
                idle_flush();
            end else begin
                addr = 32'h4000 + (32'($urandom_range(0, 3)) << 3) + (32'($urandom_range(0, 1)) << 2);
                if ($urandom_range(0, 9) == 0) addr[1:0] = 2'($urandom_range(1, 3));
                sel = $urandom_range(0, 2);
                mode = (sel == 0) ? 3'd0 : ((sel == 1) ? 3'd3 : 3'd7);
                fetch(addr, mode, 1'($urandom_range(0, 1)), $urandom_range(0, 6),
                      {$urandom, $urandom}, ($urandom_range(0, 7) == 0), 1'b0, 32'h0);
                if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 2));
            end
        end
        idle(3);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
